ntt_out_serializer: RTL

- Drains the NTT core's parallel result beats (INPUT_PER_CYCLE coefficients per beat) into a one-coefficient-per-cycle stream with valid/ready backpressure.
- Output-side counterpart to the input deserializer at the NTT_Top boundary; sits between the core's outData/out_start and the narrow downstream sink (DMA/host link).
- Buffers beats in a small vector FIFO, marks polynomial boundaries and flags overflow and framing errors.

---
 rtl/ntt_ser_pkg.sv | 26 ++
 rtl/ntt_vec_fifo.sv | 57 +++++
 rtl/ntt_out_serializer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ntt_ser_pkg.sv
// rtl/ntt_ser_pkg.sv - shared types, defaults and FSM encodings for the NTT output serializer
package ntt_ser_pkg;

  // Default configuration of the NTT_Top output boundary
  localparam int DEF_W          = 28;
  localparam int DEF_P          = 32;
  localparam int DEF_N          = 1024;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic [DEF_W-1:0]       coef_t;
  typedef logic [DEF_P*DEF_W-1:0] beat_t;

  localparam int BEATS_PER_POLY = DEF_N / DEF_P;
  localparam int LANE_W         = $clog2(DEF_P);
  localparam int CNT_W          = $clog2(DEF_N);

  // Serializer FSM encodings
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Counter width that never collapses to zero bits
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ntt_vec_fifo.sv
// rtl/ntt_vec_fifo.sv - synchronous vector FIFO holding whole input beats
module ntt_vec_fifo
  import ntt_ser_pkg::*;
#(
  parameter int DATA_W = DEF_P * DEF_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for storage and pointers; push and pop may coincide
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointers reset; storage contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ntt_out_serializer.sv
// rtl/ntt_out_serializer.sv - drains NTT result beats into a one-coefficient-per-cycle stream (optional stats: NTT_SER_STATS_EN)
module ntt_out_serializer
  import ntt_ser_pkg::*;
#(
  parameter int DATA_WIDTH_PER_INPUT = DEF_W,
  parameter int INPUT_PER_CYCLE      = DEF_P,
  parameter int POLY_SIZE            = DEF_N,
  parameter int FIFO_DEPTH           = DEF_FIFO_DEPTH
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  input  logic                                            in_first,
  input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] in_data,
  output logic                                            in_ready,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [DATA_WIDTH_PER_INPUT-1:0]                 out_data,
  output logic                                            out_first,
  output logic                                            out_last,
  output logic                                            overflow,
  output logic                                            err_framing
`ifdef NTT_SER_STATS_EN
  ,
  output logic [31:0]                                     stat_polys,
  output logic [31:0]                                     stat_stalls
`endif
);

  localparam int W     = DATA_WIDTH_PER_INPUT;
  localparam int P     = INPUT_PER_CYCLE;
  localparam int N     = POLY_SIZE;
  localparam int BEATS = N / P;
  localparam int LW    = clog2_min1(P);
  localparam int CW    = clog2_min1(N);
  localparam int BW    = clog2_min1(BEATS);

  logic             fifo_full, fifo_empty, fifo_pop, push, hs, last_lane;
  logic [P*W-1:0]   fifo_data;

  logic [0:0]       state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [P*W-1:0]   vec_q, vec_d;
  logic [CW-1:0]    coef_cnt_q, coef_cnt_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             overflow_q, overflow_d;
  logic             err_framing_q, err_framing_d;

  ntt_vec_fifo #(
    .DATA_W (P * W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // in_ready comes straight from FIFO state: a pop never frees space in the same cycle
  assign in_ready    = !fifo_full;
  assign push        = in_valid && in_ready;
  assign out_valid   = (state_q == ST_SHIFT);
  assign hs          = out_valid && out_ready;
  assign last_lane   = (lane_q == LW'(P - 1));
  assign out_data    = vec_q[lane_q*W +: W];
  assign out_first   = out_valid && (coef_cnt_q == '0);
  assign out_last    = out_valid && (coef_cnt_q == CW'(N - 1));
  assign overflow    = overflow_q;
  assign err_framing = err_framing_q;

  // Serializer FSM: load a vector, shift lanes out, reload back-to-back without a bubble
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    vec_d    = vec_q;
    fifo_pop = 1'b0;
    if (state_q == ST_IDLE) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        vec_d    = fifo_data;
        lane_d   = '0;
        state_d  = ST_SHIFT;
      end
    end else if (hs) begin
      if (!last_lane) begin
        lane_d = lane_q + LW'(1);
      end else if (!fifo_empty) begin
        fifo_pop = 1'b1;
        vec_d    = fifo_data;
        lane_d   = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Polynomial position counters and sticky error flags
  always_comb begin
    coef_cnt_d    = coef_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    overflow_d    = overflow_q;
    err_framing_d = err_framing_q;
    if (hs) begin
      coef_cnt_d = (coef_cnt_q == CW'(N - 1)) ? '0 : coef_cnt_q + CW'(1);
    end
    if (push) begin
      beat_cnt_d = (beat_cnt_q == BW'(BEATS - 1)) ? '0 : beat_cnt_q + BW'(1);
      // A misplaced start marker is only reported; the beat counter keeps its own count
      if (in_first != (beat_cnt_q == '0)) begin
        err_framing_d = 1'b1;
      end
    end
    // The core cannot stall, so a beat offered while full is lost
    if (in_valid && !in_ready) begin
      overflow_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lane_q        <= '0;
      vec_q         <= '0;
      coef_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      err_framing_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      vec_q         <= vec_d;
      coef_cnt_q    <= coef_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      overflow_q    <= overflow_d;
      err_framing_q <= err_framing_d;
    end
  end

`ifdef NTT_SER_STATS_EN
  logic [31:0] stat_polys_q, stat_polys_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  assign stat_polys  = stat_polys_q;
  assign stat_stalls = stat_stalls_q;

  // Saturating counts of completed polynomials and sink stall cycles
  always_comb begin
    stat_polys_d  = stat_polys_q;
    stat_stalls_d = stat_stalls_q;
    if (hs && out_last && (stat_polys_q != '1)) begin
      stat_polys_d = stat_polys_q + 32'd1;
    end
    if (out_valid && !out_ready && (stat_stalls_q != '1)) begin
      stat_stalls_d = stat_stalls_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_polys_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_polys_q  <= stat_polys_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end
`endif

endmodule
